// File: rtl/pill_pkg.sv
// Shared types and constants for the pill batch controller.
package pill_pkg;

  // Largest value an operator can type (two decimal digits).
  localparam int MAX_VAL = 99;
  // Binary width needed to hold any entered value or counter.
  localparam int VAL_W = $clog2(MAX_VAL + 1);

  // Keypad codes beyond the decimal digits.
  localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
  localparam logic [3:0] KEY_ENTER     = 4'hA;
  localparam logic [3:0] KEY_CLEAR     = 4'hB;

  // Controller states; the encoding is visible on the state output.
  typedef enum logic [2:0] {
    ST_SET_PER = 3'd0,
    ST_SET_BOT = 3'd1,
    ST_READY   = 3'd2,
    ST_RUN     = 3'd3,
    ST_PAUSE   = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // One-hot indicator pattern for a state (bit n set for state n).
  function automatic logic [5:0] state_led(input state_e s);
    return 6'(1) << s;
  endfunction

endpackage

// File: rtl/digit_entry.sv
// Two-digit decimal accumulator for keypad value entry.
module digit_entry
  import pill_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             digit_valid,
  input  logic [3:0]       digit,
  input  logic             clear,
  output logic [VAL_W-1:0] entry
);

  logic [VAL_W-1:0] entry_q;
  logic [VAL_W-1:0] entry_d;

  // Shift the new digit in, keeping only the last two decimal digits; clear wins.
  always_comb begin
    entry_d = entry_q;
    if (clear) begin
      entry_d = '0;
    end else if (digit_valid) begin
      entry_d = ((entry_q % VAL_W'(10)) * VAL_W'(10)) + VAL_W'(digit);
    end
  end

  // Entry register.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry = entry_q;

endmodule

// File: rtl/pill_batch_ctrl.sv
// Batch sequencing controller: value entry, then counting pills into bottles.
module pill_batch_ctrl
  import pill_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  input  logic             start,
  input  logic             pause,
  input  logic             pill,
  output logic [VAL_W-1:0] entry,
  output logic [VAL_W-1:0] per_bottle,
  output logic [VAL_W-1:0] target,
  output logic [VAL_W-1:0] pill_cnt,
  output logic [VAL_W-1:0] bottle_cnt,
  output logic [2:0]       state,
  output logic [5:0]       led,
  output logic             done
);

  state_e           state_q, state_d;
  logic [VAL_W-1:0] per_q, per_d;
  logic [VAL_W-1:0] tgt_q, tgt_d;
  logic [VAL_W-1:0] pill_q, pill_d;
  logic [VAL_W-1:0] bot_q, bot_d;
  logic [5:0]       led_q, led_d;
  logic             done_q, done_d;

  logic             key_digit, key_enter, key_clear;
  logic             in_set;
  logic             entry_clr;
  logic             go_clear;
  logic [VAL_W-1:0] entry_val;
  logic [VAL_W-1:0] pill_inc;
  logic [VAL_W-1:0] bot_inc;

  assign key_digit = key_valid && (key_code <= KEY_DIGIT_MAX);
  assign key_enter = key_valid && (key_code == KEY_ENTER);
  assign key_clear = key_valid && (key_code == KEY_CLEAR);
  assign in_set    = (state_q == ST_SET_PER) || (state_q == ST_SET_BOT);
  assign pill_inc  = pill_q + VAL_W'(1);
  assign bot_inc   = bot_q + VAL_W'(1);

  // The accumulator is zeroed by CLEAR while typing, by an accepted ENTER,
  // and by the global clear from READY/PAUSE/DONE.
  digit_entry u_digit_entry (
    .clk         (clk),
    .rst         (rst),
    .digit_valid (key_digit && in_set),
    .digit       (key_code),
    .clear       ((key_clear && in_set) || entry_clr || go_clear),
    .entry       (entry_val)
  );

  // State and datapath registers; everything visible outside is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_SET_PER;
      per_q   <= '0;
      tgt_q   <= '0;
      pill_q  <= '0;
      bot_q   <= '0;
      led_q   <= 6'b000001;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      tgt_q   <= tgt_d;
      pill_q  <= pill_d;
      bot_q   <= bot_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

  // Next state and counter updates. A key that acts wins over start, start
  // over pause; a pill in RUN is always counted before pause is considered.
  always_comb begin
    state_d   = state_q;
    per_d     = per_q;
    tgt_d     = tgt_q;
    pill_d    = pill_q;
    bot_d     = bot_q;
    entry_clr = 1'b0;
    go_clear  = 1'b0;
    unique case (state_q)
      ST_SET_PER: begin
        if (key_enter && (entry_val != '0)) begin
          per_d     = entry_val;
          entry_clr = 1'b1;
          state_d   = ST_SET_BOT;
        end
      end
      ST_SET_BOT: begin
        if (key_enter && (entry_val != '0)) begin
          tgt_d     = entry_val;
          entry_clr = 1'b1;
          state_d   = ST_READY;
        end
      end
      ST_READY, ST_DONE: begin
        if (key_clear) begin
          go_clear = 1'b1;
        end else if (start) begin
          pill_d  = '0;
          bot_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (key_clear) begin
          go_clear = 1'b1;
        end else if (start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (pill) begin
          if (pill_inc == per_q) begin
            pill_d = '0;
            bot_d  = bot_inc;
            if (bot_inc == tgt_q) begin
              state_d = ST_DONE;
            end
          end else begin
            pill_d = pill_inc;
          end
        end
        // A completing pill already moved us to DONE; pause does not override it.
        if (pause && (state_d == ST_RUN)) begin
          state_d = ST_PAUSE;
        end
      end
      default: begin
        state_d = ST_SET_PER;
      end
    endcase
    if (go_clear) begin
      state_d = ST_SET_PER;
      per_d   = '0;
      tgt_d   = '0;
      pill_d  = '0;
      bot_d   = '0;
    end
  end

  // Indicator outputs derived from the upcoming state so they register with it.
  always_comb begin
    led_d  = state_led(state_d);
    done_d = led_d[5];
  end

  assign entry      = entry_val;
  assign per_bottle = per_q;
  assign target     = tgt_q;
  assign pill_cnt   = pill_q;
  assign bottle_cnt = bot_q;
  assign state      = state_q;
  assign led        = led_q;
  assign done       = done_q;

endmodule

// File: tb/tb_pill_batch_ctrl.sv
// Scoreboard bench for pill_batch_ctrl: directed scenarios plus random traffic.
module tb_pill_batch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       pill = 1'b0;
  logic [6:0] entry, per_bottle, target, pill_cnt, bottle_cnt;
  logic [2:0] state;
  logic [5:0] led;
  logic       done;

  pill_batch_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .start      (start),
    .pause      (pause),
    .pill       (pill),
    .entry      (entry),
    .per_bottle (per_bottle),
    .target     (target),
    .pill_cnt   (pill_cnt),
    .bottle_cnt (bottle_cnt),
    .state      (state),
    .led        (led),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int ent;
    int per;
    int tgt;
    int pc;
    int bc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state (plain integers, state numbered as in the operation list).
  int m_st = 0, m_ent = 0, m_per = 0, m_tgt = 0, m_pc = 0, m_bc = 0;

  task automatic model_step(input bit r, input bit kv, input int code,
                            input bit st, input bit pa, input bit pi);
    bit kdig, kent, kclr;
    kdig = kv && (code <= 9);
    kent = kv && (code == 10);
    kclr = kv && (code == 11);
    if (r) begin
      m_st = 0; m_ent = 0; m_per = 0; m_tgt = 0; m_pc = 0; m_bc = 0;
    end else if (m_st == 0 || m_st == 1) begin
      if (kdig) m_ent = (m_ent % 10) * 10 + code;
      else if (kclr) m_ent = 0;
      else if (kent && m_ent != 0) begin
        if (m_st == 0) m_per = m_ent;
        else m_tgt = m_ent;
        m_ent = 0;
        m_st = m_st + 1;
      end
    end else if (kclr && m_st != 3) begin
      m_st = 0; m_ent = 0; m_per = 0; m_tgt = 0; m_pc = 0; m_bc = 0;
    end else if (st && (m_st == 2 || m_st == 4 || m_st == 5)) begin
      if (m_st != 4) begin
        m_pc = 0;
        m_bc = 0;
      end
      m_st = 3;
    end else if (m_st == 3) begin
      if (pi) begin
        m_pc = m_pc + 1;
        if (m_pc == m_per) begin
          m_pc = 0;
          m_bc = m_bc + 1;
          if (m_bc == m_tgt) m_st = 5;
        end
      end
      if (pa && m_st == 3) m_st = 4;
    end
  endtask

  // Drive one cycle of inputs, record the expected post-edge outputs, wait.
  task automatic cycle(input bit r, input bit kv, input int code,
                       input bit st, input bit pa, input bit pi);
    exp_t e;
    rst = r; key_valid = kv; key_code = 4'(code);
    start = st; pause = pa; pill = pi;
    model_step(r, kv, code, st, pa, pi);
    e.st = m_st; e.ent = m_ent; e.per = m_per;
    e.tgt = m_tgt; e.pc = m_pc; e.bc = m_bc;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic key(input int code);  cycle(0, 1, code, 0, 0, 0); endtask
  task automatic idle();               cycle(0, 0, 0, 0, 0, 0);    endtask
  task automatic do_start();           cycle(0, 0, 0, 1, 0, 0);    endtask
  task automatic do_pill();            cycle(0, 0, 0, 0, 0, 1);    endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one transaction per clock, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("state", int'(state), e.st);
        chk("entry", int'(entry), e.ent);
        chk("per_bottle", int'(per_bottle), e.per);
        chk("target", int'(target), e.tgt);
        chk("pill_cnt", int'(pill_cnt), e.pc);
        chk("bottle_cnt", int'(bottle_cnt), e.bc);
        chk("led", int'(led), 1 << e.st);
        chk("done", int'(done), (e.st == 5) ? 1 : 0);
        $display("txn t=%0t st=%0d ent=%0d per=%0d tgt=%0d pc=%0d bc=%0d",
                 $time, e.st, e.ent, e.per, e.tgt, e.pc, e.bc);
      end
    end
  end

  initial begin
    int r, code;
    bit kv;
    // Reset
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    // Enter 12 per bottle, 3 bottles
    key(1); key(2); key(10); key(3); key(10); idle();
    // Clear from READY, then 3 per bottle, 2 bottles, run to completion
    key(11); key(3); key(10); key(2); key(10);
    do_start();
    for (int i = 0; i < 7; i++) do_pill();
    cycle(0, 0, 0, 0, 1, 1);
    // Restart from DONE, pill+pause together, paused pills ignored, resume
    do_start();
    do_pill();
    cycle(0, 0, 0, 0, 1, 1);
    do_pill(); do_pill();
    do_start();
    do_pill();
    idle();
    // Reset mid-run with one bottle done
    cycle(1, 0, 0, 0, 0, 0);
    idle();
    // Digit rollover and ignored zero ENTER
    key(9); key(8); key(7); key(11); key(10); key(0); key(10);
    // 1 per bottle, 1 bottle, finish, clear in DONE
    key(1); key(10); key(1); key(10);
    do_start(); do_pill(); do_pill();
    key(11); idle();
    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      kv = ($urandom_range(0, 99) < 20);
      r = $urandom_range(0, 99);
      if (r < 50) code = $urandom_range(0, 3);
      else if (r < 78) code = 10;
      else if (r < 86) code = 11;
      else code = $urandom_range(0, 15);
      cycle(($urandom_range(0, 999) < 3), kv, code,
            ($urandom_range(0, 99) < 6), ($urandom_range(0, 99) < 6),
            ($urandom_range(0, 99) < 45));
    end
    idle();
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pending expected transactions, 0 required", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
